// File: rtl/crop_downsample_stream.sv
// Crop + decimate stage: samples every SX-th pixel of every SY-th line inside a window, buffered in a small FIFO.
// Optional build macro CROP_INVERT_EN: emit inverted, MSB-aligned samples instead of zero-extended ones.
module crop_downsample_stream #(
   parameter int PIX_W      = 12,
   parameter int OUT_DW     = 16,
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int X0         = 27,
   parameter int Y0         = 17,
   parameter int SX         = 21,
   parameter int SY         = 16,
   parameter int OUT_W      = 28,
   parameter int OUT_H      = 28,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 iCLK,
   input  logic                                 iRST,
   input  logic                                 iSOF,
   input  logic                                 iDVAL,
   input  logic [PIX_W-1:0]                     iDATA,
   output logic                                 oVAL,
   input  logic                                 iRDY,
   output logic [OUT_DW-1:0]                    oDATA,
   output logic [$clog2(OUT_W*OUT_H)-1:0]       oIDX,
   output logic                                 oDONE,
   output logic                                 oOVF
);
   localparam int TOTAL = OUT_W * OUT_H;
   localparam int IW    = $clog2(TOTAL);
   localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PXW   = $clog2(SX + 1);
   localparam int PYW   = $clog2(SY + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   localparam logic [XW-1:0]  X_FIRST  = XW'(X0);
   localparam logic [XW-1:0]  X_END    = XW'(X0 + SX*(OUT_W-1));
   localparam logic [XW-1:0]  X_LAST   = XW'(IMG_W - 1);
   localparam logic [YW-1:0]  Y_FIRST  = YW'(Y0);
   localparam logic [YW-1:0]  Y_END    = YW'(Y0 + SY*(OUT_H-1));
   localparam logic [YW-1:0]  Y_LAST   = YW'(IMG_H - 1);
   localparam logic [PXW-1:0] PX_LAST  = PXW'(SX - 1);
   localparam logic [PYW-1:0] PY_LAST  = PYW'(SY - 1);
   localparam logic [IW-1:0]  IDX_LAST = IW'(TOTAL - 1);
   localparam logic [CW-1:0]  FULL     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]  ONE      = CW'(1);

   generate
      if (X0 + SX*(OUT_W-1) >= IMG_W) begin : g_chk_x
         $error("crop window exceeds IMG_W");
      end
      if (Y0 + SY*(OUT_H-1) >= IMG_H) begin : g_chk_y
         $error("crop window exceeds IMG_H");
      end
      if (OUT_DW < PIX_W) begin : g_chk_w
         $error("OUT_DW must be >= PIX_W");
      end
   endgenerate

   typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;
   state_t state, state_nxt, st_eff;

   logic [XW-1:0]     x, cx, x_adv;
   logic [YW-1:0]     y, cy, y_adv;
   logic [PXW-1:0]    phx, cphx, phx_adv;
   logic [PYW-1:0]    phy, cphy, phy_adv;
   logic [AW-1:0]     rd, wr, rd_eff, wr_eff;
   logic [CW-1:0]     cnt, cnt_eff;
   logic [IW-1:0]     idx, idx_eff, cap, cap_eff;
   logic              ovf, ovf_eff;
   logic              x_last, y_last, in_win, sample, last_cap, pop, push, drop;
   logic [OUT_DW-1:0] din;
   logic [OUT_DW-1:0] mem [FIFO_DEPTH];

   // iSOF acts on this cycle's view of all state, so a pixel alongside it is (0,0)
   always_comb begin
      cx      = iSOF ? '0 : x;
      cy      = iSOF ? '0 : y;
      cphx    = iSOF ? '0 : phx;
      cphy    = iSOF ? '0 : phy;
      rd_eff  = iSOF ? '0 : rd;
      wr_eff  = iSOF ? '0 : wr;
      cnt_eff = iSOF ? '0 : cnt;
      idx_eff = iSOF ? '0 : idx;
      cap_eff = iSOF ? '0 : cap;
      ovf_eff = iSOF ? 1'b0 : ovf;
      st_eff  = iSOF ? CAPTURE : state;

      x_last  = (cx == X_LAST);
      y_last  = (cy == Y_LAST);
      x_adv   = x_last ? '0 : cx + 1'b1;
      phx_adv = (x_adv == X_FIRST) ? '0 : ((cphx == PX_LAST) ? '0 : cphx + 1'b1);
      y_adv   = cy;
      phy_adv = cphy;
      if (x_last) begin
         y_adv   = y_last ? '0 : cy + 1'b1;
         phy_adv = (y_adv == Y_FIRST) ? '0 : ((cphy == PY_LAST) ? '0 : cphy + 1'b1);
      end

      in_win   = (cx >= X_FIRST) && (cx <= X_END) && (cy >= Y_FIRST) && (cy <= Y_END) &&
                 (cphx == '0) && (cphy == '0);
      sample   = iDVAL && in_win && (st_eff == CAPTURE);
      last_cap = sample && (cap_eff == IDX_LAST);
      pop      = (cnt != '0) && iRDY && !iSOF;
      // a pop in the same cycle frees the slot for a capture into a full FIFO
      push     = sample && ((cnt_eff != FULL) || pop);
      drop     = sample && !push;
   end

`ifdef CROP_INVERT_EN
   logic [PIX_W-1:0] pix_inv;
   always_comb begin
      pix_inv = ~iDATA;
      din     = OUT_DW'(pix_inv) << (OUT_DW - PIX_W);
   end
`else
   always_comb din = OUT_DW'(iDATA);
`endif

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= CAPTURE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = st_eff;
      oDONE     = 1'b0;
      case (st_eff)
         CAPTURE: if (last_cap) state_nxt = DRAIN;
         DRAIN:   if (pop && (cnt == ONE)) begin
            state_nxt = DONE;
            oDONE     = 1'b1;
         end
         DONE:    if (iDVAL && x_last && y_last) state_nxt = CAPTURE;
         default: state_nxt = CAPTURE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         x   <= '0;
         y   <= '0;
         phx <= '0;
         phy <= '0;
         rd  <= '0;
         wr  <= '0;
         cnt <= '0;
         idx <= '0;
         cap <= '0;
         ovf <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (iDVAL) begin
            x   <= x_adv;
            y   <= y_adv;
            phx <= phx_adv;
            phy <= phy_adv;
         end else begin
            x   <= cx;
            y   <= cy;
            phx <= cphx;
            phy <= cphy;
         end
         rd  <= rd_eff + AW'(pop);
         wr  <= wr_eff + AW'(push);
         cnt <= cnt_eff + CW'(push) - CW'(pop);
         // dropped samples still advance the capture count
         cap <= last_cap ? '0 : cap_eff + IW'(sample);
         idx <= oDONE ? '0 : idx_eff + IW'(pop);
         ovf <= ovf_eff | drop;
         if (push) mem[wr_eff] <= din;
      end
   end

   assign oVAL  = (cnt != '0);
   assign oDATA = mem[rd];
   assign oIDX  = idx;
   assign oOVF  = ovf;

endmodule

// File: tb/tb_crop_downsample_stream.sv
// Scoreboard bench for crop_downsample_stream on an 8x6 image (3x2 samples); a depth-2 twin covers overflow.
module tb_crop_downsample_stream;
   localparam int PIX_W = 12;
   localparam int OUT_DW = 16;

   logic              iCLK = 1'b0;
   logic              iRST = 1'b1;
   logic              iSOF = 1'b0;
   logic              iDVAL = 1'b0;
   logic [PIX_W-1:0]  iDATA = '0;
   logic              rdy0 = 1'b0;
   logic              rdy1 = 1'b0;
   logic              val0, done0, ovf0, val1, done1, ovf1;
   logic [OUT_DW-1:0] data0, data1;
   logic [2:0]        idx0, idx1;

   crop_downsample_stream #(.PIX_W(PIX_W), .OUT_DW(OUT_DW), .IMG_W(8), .IMG_H(6), .X0(1), .Y0(1),
      .SX(2), .SY(2), .OUT_W(3), .OUT_H(2), .FIFO_DEPTH(4)) u0 (
      .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iDATA(iDATA), .oVAL(val0),
      .iRDY(rdy0), .oDATA(data0), .oIDX(idx0), .oDONE(done0), .oOVF(ovf0));

   crop_downsample_stream #(.PIX_W(PIX_W), .OUT_DW(OUT_DW), .IMG_W(8), .IMG_H(6), .X0(1), .Y0(1),
      .SX(2), .SY(2), .OUT_W(3), .OUT_H(2), .FIFO_DEPTH(2)) u1 (
      .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iDATA(iDATA), .oVAL(val1),
      .iRDY(rdy1), .oDATA(data1), .oIDX(idx1), .oDONE(done1), .oOVF(ovf1));

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [OUT_DW-1:0] d;
      logic [2:0]        i;
      logic              dn;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   px = 0;
   int   py = 0;
   int   exp_pix[6] = '{9, 11, 13, 25, 27, 29};

   function automatic logic [OUT_DW-1:0] conv(input int p);
`ifdef CROP_INVERT_EN
      logic [OUT_DW-1:0] v;
      v = OUT_DW'(4095 - p);
      return v << 4;
`else
      return OUT_DW'(p);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame();
      for (int k = 0; k < 6; k++) begin
         exp_t e;
         e.d  = conv(exp_pix[k]);
         e.i  = 3'(k);
         e.dn = (k == 5);
         q.push_back(e);
      end
   endtask

   task automatic step(input logic sof);
      iSOF  = sof;
      iDVAL = 1'b1;
      iDATA = sof ? '0 : PIX_W'(px + 8*py);
      @(posedge iCLK);
      #1;
      iSOF = 1'b0;
      if (sof) begin
         px = 1;
         py = 0;
      end else if (px == 7) begin
         px = 0;
         py = (py == 5) ? 0 : py + 1;
      end else begin
         px++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0);
   endtask

   always @(negedge iCLK) begin : mon
      exp_t e;
      if (iRST) begin
         if (done0) n_done++;
         if (val0 && rdy0) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_sample: got data %0h idx %0d, expected none", data0, idx0);
            end else begin
               e = q.pop_front();
               chk("sample_data", 32'(data0), 32'(e.d));
               chk("sample_idx", 32'(idx0), 32'(e.i));
               chk("sample_done", 32'(done0), 32'(e.dn));
            end
         end else if (done0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done: got oDONE=1 without transfer, expected 0");
         end
      end
   end

   initial begin
      #2 iRST = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_val", 32'(val0), 0);
      chk("rst_data", 32'(data0), 0);
      chk("rst_idx", 32'(idx0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_ovf", 32'(ovf0), 0);
      chk("rst_ovf1", 32'(ovf1), 0);
      iRST = 1'b1;

      // continuous stream, always ready
      rdy0 = 1'b1;
      push_frame();
      run(48);
      chk("s1_drained", 32'(q.size()), 0);
      chk("s1_ovf", 32'(ovf0), 0);

      // two back-to-back frames
      push_frame();
      run(48);
      push_frame();
      run(48);
      chk("s2_drained", 32'(q.size()), 0);

      // downstream stalled for the first sample row
      rdy0 = 1'b0;
      push_frame();
      run(14);
      chk("s3_val", 32'(val0), 1);
      chk("s3_data", 32'(data0), 32'(conv(9)));
      chk("s3_idx", 32'(idx0), 0);
      run(2);
      chk("s3_val_hold", 32'(val0), 1);
      chk("s3_data_hold", 32'(data0), 32'(conv(9)));
      rdy0 = 1'b1;
      run(32);
      chk("s3_drained", 32'(q.size()), 0);

      // overflow on the depth-2 instance; frame starts with iSOF on pixel (0,0)
      chk("s4_ovf1_sticky", 32'(ovf1), 1);
      push_frame();
      step(1'b1);
      chk("s4_sof_ovf1", 32'(ovf1), 0);
      chk("s4_sof_val1", 32'(val1), 0);
      run(11);
      chk("s4_ovf1_pre", 32'(ovf1), 0);
      chk("s4_val1", 32'(val1), 1);
      chk("s4_data1", 32'(data1), 32'(conv(9)));
      run(1);
      chk("s4_ovf1_before13", 32'(ovf1), 0);
      run(1);
      chk("s4_ovf1_after13", 32'(ovf1), 1);
      run(34);
      chk("s4_drained", 32'(q.size()), 0);

      // mid-frame iSOF after three transfers
      push_frame();
      run(16);
      rdy0 = 1'b0;
      run(12);
      chk("s5_pending_val", 32'(val0), 1);
      chk("s5_pending_data", 32'(data0), 32'(conv(25)));
      chk("s5_pending_idx", 32'(idx0), 3);
      q.delete();
      push_frame();
      step(1'b1);
      chk("s5_sof_val", 32'(val0), 0);
      chk("s5_sof_idx", 32'(idx0), 0);
      chk("s5_sof_val1", 32'(val1), 0);
      chk("s5_sof_ovf1", 32'(ovf1), 0);
      rdy0 = 1'b1;
      run(47);

      iDVAL = 1'b0;
      repeat (5) @(posedge iCLK);
      #1;
      chk("end_drained", 32'(q.size()), 0);
      chk("done_count", 32'(n_done), 6);
      chk("end_ovf", 32'(ovf0), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
